// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port single-memory arbiter with optional exclusive locking.
//            An idle arbiter grants a lone requester, or breaks a tie by the
//            configured rule. A port granted with its lock flag set takes
//            exclusive ownership until it drops lock, or until LOCK_MAX
//            cycles elapse. On that forced release lock_abort pulses, and the
//            port may not re-lock while the other port is still waiting.
// Config   : `define MEM_ARBITER_ROUND_ROBIN_EN -> idle tie goes to the port
//            that was not granted last. Undefined -> the tie always goes to
//            port 0.
// Ports    : clk_i, rst_ni             clock, async active-low reset
//            pX_req_i/we_i/lock_i      per-port request, write, lock request
//            pX_addr_i/wdata_i         per-port address / write data
//            pX_gnt_o                  combinational grant
//            pX_rvalid_o/rdata_o       registered read valid, read data
//            mem_en_o/we_o/addr_o/
//            wdata_o/rdata_i           memory side
//            lock_abort_o              registered forced-release pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p0_req_i,
  input  logic        p0_we_i,
  input  logic        p0_lock_i,
  input  logic [31:0] p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  input  logic        p1_req_i,
  input  logic        p1_we_i,
  input  logic        p1_lock_i,
  input  logic [31:0] p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p0_gnt_o,
  output logic        p1_gnt_o,
  output logic        p0_rvalid_o,
  output logic        p1_rvalid_o,
  output logic [31:0] p0_rdata_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        lock_abort_o
);

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e      state_q;
  logic        last_q;       // most recently granted port
  logic [7:0]  cnt_q;        // cycles spent in the current lock
  logic        p0_rvalid_q;
  logic        p1_rvalid_q;
  logic        abort_q;
  logic        blk_q;        // a timed-out port is barred from re-locking
  logic        blk_port_q;   // which port is barred

  logic gnt0;
  logic gnt1;
  logic lock_ok0;
  logic lock_ok1;

  // Grant decode. Gated by reset so that nothing reaches memory while reset
  // is held, even in the middle of a clock cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_ni) begin
      case (state_q)
        ST_LOCK0: gnt0 = p0_req_i;
        ST_LOCK1: gnt1 = p1_req_i;
        default: begin
          if (p0_req_i && p1_req_i) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            gnt0 = last_q;
            gnt1 = ~last_q;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = p0_req_i;
            gnt1 = p1_req_i;
          end
        end
      endcase
    end
  end

  // A barred port may still lock once the other port is no longer waiting.
  assign lock_ok0 = !(blk_q && !blk_port_q && p1_req_i);
  assign lock_ok1 = !(blk_q &&  blk_port_q && p0_req_i);

  assign p0_gnt_o    = gnt0;
  assign p1_gnt_o    = gnt1;
  assign mem_en_o    = gnt0 | gnt1;
  assign mem_we_o    = gnt0 ? p0_we_i    : (gnt1 ? p1_we_i    : 1'b0);
  assign mem_addr_o  = gnt0 ? p0_addr_i  : (gnt1 ? p1_addr_i  : 32'd0);
  assign mem_wdata_o = gnt0 ? p0_wdata_i : (gnt1 ? p1_wdata_i : 32'd0);

  assign p0_rdata_o   = mem_rdata_i;
  assign p1_rdata_o   = mem_rdata_i;
  assign p0_rvalid_o  = p0_rvalid_q;
  assign p1_rvalid_o  = p1_rvalid_q;
  assign lock_abort_o = abort_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= 8'd0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      abort_q     <= 1'b0;
      blk_q       <= 1'b0;
      blk_port_q  <= 1'b0;
    end else begin
      p0_rvalid_q <= gnt0 & ~p0_we_i;
      p1_rvalid_q <= gnt1 & ~p1_we_i;
      abort_q     <= 1'b0;

      if (gnt0) begin
        last_q <= 1'b0;
      end else if (gnt1) begin
        last_q <= 1'b1;
      end

      // The bar lifts once the other port is served or stops asking.
      if (blk_q) begin
        if (blk_port_q ? (gnt0 || !p0_req_i) : (gnt1 || !p1_req_i)) begin
          blk_q <= 1'b0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (gnt0 && p0_lock_i && lock_ok0) begin
            state_q <= ST_LOCK0;
            cnt_q   <= 8'd1;
          end else if (gnt1 && p1_lock_i && lock_ok1) begin
            state_q <= ST_LOCK1;
            cnt_q   <= 8'd1;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          // A voluntary release wins over a coincident timeout.
          if (state_q == ST_LOCK0 ? !p0_lock_i : !p1_lock_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
          end else if (cnt_q == LOCK_MAX_C) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            last_q     <= (state_q == ST_LOCK1);
            abort_q    <= 1'b1;
            blk_q      <= 1'b1;
            blk_port_q <= (state_q == ST_LOCK1);
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (LOCK_MAX = 4).
//            Inputs change on the falling edge; outputs are checked 1 ns
//            later, well away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p0_lock;
  logic [31:0] p0_addr, p0_wdata;
  logic        p1_req, p1_we, p1_lock;
  logic [31:0] p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        lock_abort;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .p0_req_i     (p0_req),
    .p0_we_i      (p0_we),
    .p0_lock_i    (p0_lock),
    .p0_addr_i    (p0_addr),
    .p0_wdata_i   (p0_wdata),
    .p1_req_i     (p1_req),
    .p1_we_i      (p1_we),
    .p1_lock_i    (p1_lock),
    .p1_addr_i    (p1_addr),
    .p1_wdata_i   (p1_wdata),
    .p0_gnt_o     (p0_gnt),
    .p1_gnt_o     (p1_gnt),
    .p0_rvalid_o  (p0_rvalid),
    .p1_rvalid_o  (p1_rvalid),
    .p0_rdata_o   (p0_rdata),
    .p1_rdata_o   (p1_rdata),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .lock_abort_o (lock_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Next falling edge, then let combinational outputs settle.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    cyc(); clear_inputs(); rst_n = 0;
    cyc(); rst_n = 1;
  endtask

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam logic [3:0] CONT_P1 = 4'b1010;   // p1 wins cycles 1 and 3
  localparam logic       TO_P1   = 1'b1;      // post-timeout tie goes to p1
`else
  localparam logic [3:0] CONT_P1 = 4'b0000;
  localparam logic       TO_P1   = 1'b0;
`endif

  initial begin
    logic [3:0] cont;
    logic       to_p1;
    cont  = CONT_P1;
    to_p1 = TO_P1;
    clear_inputs();
    mem_rdata = 0;
    rst_n = 0;

    // ---- reset state, with a read pending --------------------------------
    cyc(); p0_req = 1; settle();
    chk_eq("rst_p0_gnt", p0_gnt, 0);
    chk_eq("rst_p1_gnt", p1_gnt, 0);
    chk_eq("rst_mem_en", mem_en, 0);
    chk_eq("rst_mem_we", mem_we, 0);
    chk_eq("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk_eq("rst_abort", lock_abort, 0);
    cyc(); p0_req = 0; rst_n = 1;

    // ---- single read ------------------------------------------------------
    cyc(); p0_req = 1; p0_addr = 32'h10; settle();
    chk_eq("rd_p0_gnt", p0_gnt, 1);
    chk_eq("rd_p1_gnt", p1_gnt, 0);
    chk_eq("rd_mem_en", mem_en, 1);
    chk_eq("rd_mem_we", mem_we, 0);
    chk_eq("rd_mem_addr", mem_addr, 32'h10);
    cyc(); clear_inputs(); mem_rdata = 32'hDEADBEEF; settle();
    chk_eq("rd_p0_rvalid", p0_rvalid, 1);
    chk_eq("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk_eq("rd_p1_rvalid", p1_rvalid, 0);
    chk_eq("idle_mem_en", mem_en, 0);
    chk_eq("idle_mem_addr", mem_addr, 0);
    chk_eq("idle_mem_wdata", mem_wdata, 0);
    cyc(); settle();
    chk_eq("rd_p0_rvalid_once", p0_rvalid, 0);

    // ---- single write on p1 -----------------------------------------------
    cyc(); p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678; settle();
    chk_eq("wr_p1_gnt", p1_gnt, 1);
    chk_eq("wr_mem_we", mem_we, 1);
    chk_eq("wr_mem_addr", mem_addr, 32'h20);
    chk_eq("wr_mem_wdata", mem_wdata, 32'h12345678);
    cyc(); clear_inputs(); settle();
    chk_eq("wr_no_rvalid", {p0_rvalid, p1_rvalid}, 0);

    // ---- contention: both ports read for 4 cycles -------------------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      p0_req = 1; p0_addr = 32'h100; p1_req = 1; p1_addr = 32'h200;
      settle();
      chk_eq($sformatf("cont_p0_gnt%0d", i), p0_gnt, !cont[i]);
      chk_eq($sformatf("cont_p1_gnt%0d", i), p1_gnt, cont[i]);
      chk_eq($sformatf("cont_addr%0d", i), mem_addr, cont[i] ? 32'h200 : 32'h100);
      if (i > 0)
        chk_eq($sformatf("cont_rvalid%0d", i), {p1_rvalid, p0_rvalid},
               cont[i-1] ? 32'd2 : 32'd1);
    end
    cyc(); clear_inputs(); settle();
    chk_eq("cont_rvalid_last", {p1_rvalid, p0_rvalid}, cont[3] ? 32'd2 : 32'd1);

    // ---- lock held by p1, released together with count = LOCK_MAX --------
    do_reset();
    p1_req = 1; p1_lock = 1; settle();
    chk_eq("lk_enter_p1_gnt", p1_gnt, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(); p0_req = 1; p1_req = 1; p1_lock = (i < 4); settle();
      chk_eq($sformatf("lk_p0_gnt%0d", i), p0_gnt, 0);
      chk_eq($sformatf("lk_p1_gnt%0d", i), p1_gnt, 1);
    end
    cyc(); p1_req = 0; p1_lock = 0; settle();
    chk_eq("lk_after_p0_gnt", p0_gnt, 1);
    chk_eq("lk_release_no_abort", lock_abort, 0);
    cyc(); clear_inputs(); settle();
    chk_eq("lk_release_no_abort2", lock_abort, 0);

    // ---- lock timeout on p0 ------------------------------------------------
    do_reset();
    p0_req = 1; p0_lock = 1; settle();
    chk_eq("to_enter_p0_gnt", p0_gnt, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(); p1_req = 1; settle();
      chk_eq($sformatf("to_p1_gnt%0d", i), p1_gnt, 0);
      chk_eq($sformatf("to_abort%0d", i), lock_abort, 0);
    end
    cyc(); settle();   // p0 still asks for lock, p1 waiting
    chk_eq("to_abort_pulse", lock_abort, 1);
    chk_eq("to_tie_p1_gnt", p1_gnt, to_p1);
    chk_eq("to_tie_p0_gnt", p0_gnt, !to_p1);
    cyc(); p0_req = 0; settle();
    chk_eq("to_not_relocked_p1_gnt", p1_gnt, 1);
    chk_eq("to_abort_one_cycle", lock_abort, 0);
    cyc(); p0_req = 1; p1_req = 0; settle();
    chk_eq("to_relock_p0_gnt", p0_gnt, 1);
    cyc(); p0_req = 0; p1_req = 1; settle();
    chk_eq("to_relocked_p1_blocked", p1_gnt, 0);
    cyc(); p0_lock = 0; settle();
    chk_eq("to_release_p1_blocked", p1_gnt, 0);
    cyc(); settle();
    chk_eq("to_after_release_p1_gnt", p1_gnt, 1);

    // ---- reset asserted while p0 read is granted ---------------------------
    cyc(); clear_inputs(); p0_req = 1; settle();
    chk_eq("mr_p0_gnt", p0_gnt, 1);
    #2 rst_n = 0; settle();
    chk_eq("mr_p0_gnt_rst", p0_gnt, 0);
    chk_eq("mr_mem_en_rst", mem_en, 0);
    chk_eq("mr_mem_we_rst", mem_we, 0);
    cyc(); p0_req = 0; rst_n = 1; settle();
    chk_eq("mr_no_rvalid", p0_rvalid, 0);
    chk_eq("mr_no_abort", lock_abort, 0);
    cyc(); p1_req = 1; settle();
    chk_eq("mr_idle_p1_gnt", p1_gnt, 1);

    // ---- reset while p1 owns a lock ---------------------------------------
    cyc(); clear_inputs(); p1_req = 1; p1_lock = 1; settle();
    chk_eq("rl_enter_p1_gnt", p1_gnt, 1);
    cyc(); rst_n = 0; settle();
    cyc(); rst_n = 1; p0_req = 1; p1_req = 0; settle();
    chk_eq("rl_dropped_p0_gnt", p0_gnt, 1);
    chk_eq("rl_no_abort", lock_abort, 0);
    cyc(); clear_inputs(); settle();
    chk_eq("rl_no_abort2", lock_abort, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 16: maximum consecutive cycles one port holds a lock; legal range 2..255.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 p0_req / p1_req  input  1  port requests one memory access this cycle.
REQ-005 p0_we / p1_we  input  1  1 = write, 0 = read; qualified by req.
REQ-006 p0_lock / p1_lock  input  1  port requests exclusive ownership after this access.
REQ-007 p0_addr / p1_addr  input  32  word address.
REQ-008 p0_wdata / p1_wdata  input  32  write data.
REQ-009 p0_gnt / p1_gnt  output  1  access accepted this cycle (combinational).
REQ-010 p0_rvalid / p1_rvalid  output  1  registered; read data for this port is on rdata.
REQ-011 p0_rdata / p1_rdata  output  32  both driven directly from mem_rdata.
REQ-012 mem_en  output  1  memory access this cycle.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  32  memory address.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_rdata  input  32  memory read data, valid the cycle after a read access.
REQ-017 lock_abort  output  1  registered one-cycle pulse when a lock is forcibly released.

Function
REQ-018 FSM states: IDLE, LOCK0, LOCK1; at most one grant per cycle; a grant requires req=1.
REQ-019 IDLE, exactly one req: that port is granted.
REQ-020 IDLE, both req: winner is set by tie-break rule (REQ-040/041); the loser's gnt is 0 and it must hold its request.
REQ-021 LOCKx: only port x may be granted; the other port's req is ignored (gnt 0).
REQ-022 Granted access: mem_en=1; mem_addr, mem_we and mem_wdata are taken from the winner in the same cycle.
REQ-023 No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Granted read in cycle N: that port's rvalid=1 in cycle N+1 only; granted writes never raise rvalid.
REQ-025 Back-to-back reads, alternating or same port: one rvalid per read, in grant order, one cycle latency each.
REQ-026 Register `last` holds the most recently granted port; it updates on every grant.
REQ-027 IDLE -> LOCKx on a grant to port x with px_lock=1.
REQ-028 LOCKx -> IDLE at the edge ending a cycle with px_lock=0; port x's request in that cycle is still granted.
REQ-029 The lock counter loads 1 on entry to LOCKx and increments each cycle spent in LOCKx.
REQ-030 Lock timeout: at count = LOCK_MAX the FSM goes to IDLE, `last` is set to x, and lock_abort pulses in the next cycle.
REQ-031 After a timeout, port x cannot re-enter LOCKx until one grant has gone to the other port, or until a cycle in which the other port has req=0.
REQ-032 Simultaneous lock release and timeout: treated as a normal release; lock_abort stays 0.

Reset
REQ-033 reset low (asynchronous): state=IDLE, last=1, counter=0, p0_rvalid=p1_rvalid=0, lock_abort=0.
REQ-034 Combinational outputs during reset: p0_gnt=p1_gnt=0, mem_en=0, mem_we=0.
REQ-035 A read granted in the cycle reset asserts produces no rvalid after reset release.
REQ-036 Reset asserted while in LOCKx: ownership is dropped immediately; no lock_abort.
REQ-037 First rising edge after reset deassertion: normal arbitration from IDLE.

Configuration
REQ-038 Macro MEM_ARBITER_ROUND_ROBIN_EN selects the IDLE tie-break rule.
REQ-039 Timeout behaviour (REQ-030, REQ-031) applies with or without the macro.
REQ-040 With MEM_ARBITER_ROUND_ROBIN_EN defined: tie goes to the port != `last` (port 0 wins the first tie after reset).
REQ-041 Without it: tie always goes to port 0; `last` is kept only for the timeout rule.

Verification
REQ-042 Single read: p0 reads addr 0x10, memory returns 0xDEADBEEF -> p0_gnt same cycle, mem_addr=0x10, p0_rvalid=1 next cycle with p0_rdata=0xDEADBEEF, p1_rvalid=0.
REQ-043 Contention: both ports hold reads for 4 cycles -> with RR enabled grants go 0,1,0,1; without it 0,0,0,0 and p1 is never granted.
REQ-044 Lock: p1 granted with lock=1, p0 requests, p1 holds lock for 3 cycles -> p0_gnt=0 for those cycles; p0 granted on the first cycle after p1_lock falls.
REQ-045 Timeout (LOCK_MAX=4): p0 holds lock while p1 requests -> lock_abort pulses, p1 granted next, p0 re-lock honoured only after that grant.
REQ-046 Reset mid-read: reset low in the cycle p0's read is granted -> no p0_rvalid; state IDLE; outputs match REQ-033/034.
